// File: rtl/ctr_buffer_if.sv
// ctr_buffer_if: record input, CSR read/write and debug signals of the CTR record buffer
// master = record/CSR producer side, slave = ctr_buffer
interface ctr_buffer_if #(
  parameter int NrCommitPorts = 2,
  parameter int NumEntries    = 16,
  parameter int XLEN          = 64,
  parameter int IdxW          = 8
);
  localparam int PtrW = $clog2(NumEntries);
  logic [NrCommitPorts*XLEN-1:0] source_i;
  logic [NrCommitPorts*XLEN-1:0] target_i;
  logic [NrCommitPorts*32-1:0]   data_i;
  logic                          freeze_i;
  logic                          clear_i;
  logic                          rd_req_i;
  logic [IdxW-1:0]               rd_idx_i;
  logic                          rd_valid_o;
  logic [XLEN-1:0]               rd_source_o;
  logic [XLEN-1:0]               rd_target_o;
  logic [31:0]                   rd_data_o;
  logic                          wr_en_i;
  logic [IdxW-1:0]               wr_idx_i;
  logic [1:0]                    wr_sel_i;
  logic [XLEN-1:0]               wr_data_i;
  logic [PtrW-1:0]               wptr_o;
  modport master (
    output source_i, target_i, data_i, freeze_i, clear_i, rd_req_i, rd_idx_i,
           wr_en_i, wr_idx_i, wr_sel_i, wr_data_i,
    input  rd_valid_o, rd_source_o, rd_target_o, rd_data_o, wptr_o
  );
  modport slave (
    input  source_i, target_i, data_i, freeze_i, clear_i, rd_req_i, rd_idx_i,
           wr_en_i, wr_idx_i, wr_sel_i, wr_data_i,
    output rd_valid_o, rd_source_o, rd_target_o, rd_data_o, wptr_o
  );
endinterface

// File: rtl/ctr_buffer.sv
// ctr_buffer: circular CTR record buffer, logical entry 0 = newest record
// clk_i/rst_i: clock and async active-high reset
// bus: per-port records in, freeze/clear, 1-cycle CSR read port, CSR field write port, wptr debug out
module ctr_buffer #(
  parameter int NrCommitPorts = 2,
  parameter int NumEntries    = 16,
  parameter int XLEN          = 64,
  parameter int IdxW          = 8
) (
  input logic        clk_i,
  input logic        rst_i,
  ctr_buffer_if.slave bus
);
  localparam int PtrW = $clog2(NumEntries);
  logic [XLEN-1:0] src_q [NumEntries];
  logic [XLEN-1:0] src_d [NumEntries];
  logic [XLEN-1:0] tgt_q [NumEntries];
  logic [XLEN-1:0] tgt_d [NumEntries];
  logic [31:0]     dat_q [NumEntries];
  logic [31:0]     dat_d [NumEntries];
  logic [PtrW-1:0] wptr_q, wptr_d, newest, rd_slot, wr_slot;
  logic            rd_ok, wr_ok, rd_valid_q;
  logic [XLEN-1:0] rd_src_q, rd_tgt_q;
  logic [31:0]     rd_dat_q;
  assign newest  = wptr_q - PtrW'(1);
  assign rd_slot = newest - bus.rd_idx_i[PtrW-1:0];
  assign wr_slot = newest - bus.wr_idx_i[PtrW-1:0];
  assign rd_ok   = 32'(bus.rd_idx_i) < NumEntries;
  assign wr_ok   = bus.wr_en_i && 32'(bus.wr_idx_i) < NumEntries && bus.wr_sel_i != 2'd3;
  // CSR write first, then records, so a record landing on the same slot overrides it;
  // clear last so it overrides everything.
  always_comb begin
    src_d  = src_q;
    tgt_d  = tgt_q;
    dat_d  = dat_q;
    wptr_d = wptr_q;
    if (wr_ok && bus.wr_sel_i == 2'd0) src_d[wr_slot] = bus.wr_data_i;
    if (wr_ok && bus.wr_sel_i == 2'd1) tgt_d[wr_slot] = bus.wr_data_i;
    if (wr_ok && bus.wr_sel_i == 2'd2) dat_d[wr_slot] = bus.wr_data_i[31:0];
    for (int i = 0; i < NrCommitPorts; i++) begin
      if (!bus.freeze_i && bus.source_i[i*XLEN]) begin
        src_d[wptr_d] = bus.source_i[i*XLEN +: XLEN];
        tgt_d[wptr_d] = bus.target_i[i*XLEN +: XLEN];
        dat_d[wptr_d] = bus.data_i[i*32 +: 32];
        wptr_d        = wptr_d + PtrW'(1);
      end
    end
    if (bus.clear_i) begin
      for (int k = 0; k < NumEntries; k++) begin
        src_d[k] = '0;
        tgt_d[k] = '0;
        dat_d[k] = '0;
      end
      wptr_d = '0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q      <= '{default: '0};
      tgt_q      <= '{default: '0};
      dat_q      <= '{default: '0};
      wptr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_src_q   <= '0;
      rd_tgt_q   <= '0;
      rd_dat_q   <= '0;
    end else begin
      src_q      <= src_d;
      tgt_q      <= tgt_d;
      dat_q      <= dat_d;
      wptr_q     <= wptr_d;
      rd_valid_q <= bus.rd_req_i;
      if (bus.rd_req_i) begin
        rd_src_q <= rd_ok ? src_q[rd_slot] : '0;
        rd_tgt_q <= rd_ok ? tgt_q[rd_slot] : '0;
        rd_dat_q <= rd_ok ? dat_q[rd_slot] : '0;
      end
    end
  end
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.rd_source_o = rd_src_q;
  assign bus.rd_target_o = rd_tgt_q;
  assign bus.rd_data_o   = rd_dat_q;
  assign bus.wptr_o      = wptr_q;
endmodule
